// File: rtl/mix_addkey_stage.sv
// AES round tail: XOR-combines R/H/T products into MixColumns, adds the round key, forwards key/Rcon/empty.
// Latency 2 edges, 1 block per cycle; no backpressure, bubbles are marked by empty and never counted.
module mix_addkey_stage (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, RA, RB, RC, RD, RE, RF,
    input  logic [7:0] H0, H1, H2, H3, H4, H5, H6, H7, H8, H9, HA, HB, HC, HD, HE, HF,
    input  logic [7:0] T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, TA, TB, TC, TD, TE, TF,
    input  logic [7:0] KA0, KA1, KA2, KA3, KA4, KA5, KA6, KA7,
    input  logic [7:0] KA8, KA9, KAA, KAB, KAC, KAD, KAE, KAF,
    input  logic [7:0] Rcon_in,
    input  logic       final_in,
    input  logic       empty_in,
    output logic [7:0] S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SA, SB, SC, SD, SE, SF,
    output logic [7:0] KO0, KO1, KO2, KO3, KO4, KO5, KO6, KO7,
    output logic [7:0] KO8, KO9, KOA, KOB, KOC, KOD, KOE, KOF,
    output logic [7:0] Rcon_out,
    output logic       empty,
    output logic [7:0] blk_count
);

    logic [15:0][7:0] r, h, t, ka;
    logic [15:0][7:0] mix_dat;
    logic [15:0][7:0] s1_dat, s1_key;
    logic [15:0][7:0] s2_dat, s2_key;
    logic [7:0]       s1_rcon;
    logic             s1_empty;

    assign r  = {RF, RE, RD, RC, RB, RA, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};
    assign h  = {HF, HE, HD, HC, HB, HA, H9, H8, H7, H6, H5, H4, H3, H2, H1, H0};
    assign t  = {TF, TE, TD, TC, TB, TA, T9, T8, T7, T6, T5, T4, T3, T2, T1, T0};
    assign ka = {KAF, KAE, KAD, KAC, KAB, KAA, KA9, KA8, KA7, KA6, KA5, KA4, KA3, KA2, KA1, KA0};

    // Each column uses the circulant {2,3,1,1}; the products arrive precomputed.
    always_comb begin
        mix_dat = '0;
        for (int c = 0; c < 4; c++) begin
            mix_dat[4*c]   = h[4*c]   ^ t[4*c+1] ^ r[4*c+2] ^ r[4*c+3];
            mix_dat[4*c+1] = r[4*c]   ^ h[4*c+1] ^ t[4*c+2] ^ r[4*c+3];
            mix_dat[4*c+2] = r[4*c]   ^ r[4*c+1] ^ h[4*c+2] ^ t[4*c+3];
            mix_dat[4*c+3] = t[4*c]   ^ r[4*c+1] ^ r[4*c+2] ^ h[4*c+3];
        end
        if (final_in) begin
            mix_dat = r;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_dat   <= '0;
            s1_key   <= '0;
            s1_rcon  <= 8'h00;
            s1_empty <= 1'b1;
        end else begin
            s1_dat   <= mix_dat ^ ka;
            s1_key   <= ka;
            s1_rcon  <= Rcon_in;
            s1_empty <= empty_in;
        end
    end

    // The counter advances on the same edge that presents a valid block at the outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_dat    <= '0;
            s2_key    <= '0;
            Rcon_out  <= 8'h00;
            empty     <= 1'b1;
            blk_count <= 8'h00;
        end else begin
            s2_dat   <= s1_dat;
            s2_key   <= s1_key;
            Rcon_out <= s1_rcon;
            empty    <= s1_empty;
            if (!s1_empty) begin
                blk_count <= blk_count + 8'd1;
            end
        end
    end

    assign {SF, SE, SD, SC, SB, SA, S9, S8, S7, S6, S5, S4, S3, S2, S1, S0} = s2_dat;
    assign {KOF, KOE, KOD, KOC, KOB, KOA, KO9, KO8,
            KO7, KO6, KO5, KO4, KO3, KO2, KO1, KO0} = s2_key;

endmodule

// File: tb/tb_mix_addkey_stage.sv
// Scoreboard bench for mix_addkey_stage: a driver queues expected blocks, a monitor checks outputs.
module tb_mix_addkey_stage;

    typedef logic [15:0][7:0] st_t;
    typedef struct {
        st_t        s;
        st_t        ko;
        logic [7:0] rcon;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    st_t        r, h, t, ka;
    logic [7:0] rcon_in;
    logic       final_in, empty_in;
    wire  [15:0][7:0] s_o, ko_o;
    wire  [7:0] rcon_o, cnt_o;
    wire        empty_o;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] cnt_model = 8'h00;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mix_addkey_stage dut (
        .clock(clock), .reset(reset),
        .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
        .R8(r[8]), .R9(r[9]), .RA(r[10]), .RB(r[11]), .RC(r[12]), .RD(r[13]), .RE(r[14]), .RF(r[15]),
        .H0(h[0]), .H1(h[1]), .H2(h[2]), .H3(h[3]), .H4(h[4]), .H5(h[5]), .H6(h[6]), .H7(h[7]),
        .H8(h[8]), .H9(h[9]), .HA(h[10]), .HB(h[11]), .HC(h[12]), .HD(h[13]), .HE(h[14]), .HF(h[15]),
        .T0(t[0]), .T1(t[1]), .T2(t[2]), .T3(t[3]), .T4(t[4]), .T5(t[5]), .T6(t[6]), .T7(t[7]),
        .T8(t[8]), .T9(t[9]), .TA(t[10]), .TB(t[11]), .TC(t[12]), .TD(t[13]), .TE(t[14]), .TF(t[15]),
        .KA0(ka[0]), .KA1(ka[1]), .KA2(ka[2]), .KA3(ka[3]), .KA4(ka[4]), .KA5(ka[5]),
        .KA6(ka[6]), .KA7(ka[7]), .KA8(ka[8]), .KA9(ka[9]), .KAA(ka[10]), .KAB(ka[11]),
        .KAC(ka[12]), .KAD(ka[13]), .KAE(ka[14]), .KAF(ka[15]),
        .Rcon_in(rcon_in), .final_in(final_in), .empty_in(empty_in),
        .S0(s_o[0]), .S1(s_o[1]), .S2(s_o[2]), .S3(s_o[3]), .S4(s_o[4]), .S5(s_o[5]),
        .S6(s_o[6]), .S7(s_o[7]), .S8(s_o[8]), .S9(s_o[9]), .SA(s_o[10]), .SB(s_o[11]),
        .SC(s_o[12]), .SD(s_o[13]), .SE(s_o[14]), .SF(s_o[15]),
        .KO0(ko_o[0]), .KO1(ko_o[1]), .KO2(ko_o[2]), .KO3(ko_o[3]), .KO4(ko_o[4]), .KO5(ko_o[5]),
        .KO6(ko_o[6]), .KO7(ko_o[7]), .KO8(ko_o[8]), .KO9(ko_o[9]), .KOA(ko_o[10]), .KOB(ko_o[11]),
        .KOC(ko_o[12]), .KOD(ko_o[13]), .KOE(ko_o[14]), .KOF(ko_o[15]),
        .Rcon_out(rcon_o), .empty(empty_o), .blk_count(cnt_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: state matrix times circulant {2,3,1,1}; coefficient k selects the R/H/T product.
    function automatic st_t model(input st_t ri, input st_t hi, input st_t ti, input st_t ki,
                                  input logic fin);
        int   coef[4] = '{2, 3, 1, 1};
        st_t  o;
        logic [7:0] acc, p;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    case (coef[(j - i + 4) % 4])
                        1:       p = ri[4*c+j];
                        2:       p = hi[4*c+j];
                        default: p = ti[4*c+j];
                    endcase
                    acc = acc ^ p;
                end
                o[4*c+i] = (fin ? ri[4*c+i] : acc) ^ ki[4*c+i];
            end
        end
        return o;
    endfunction

    function automatic st_t rnd_st();
        st_t o;
        for (int i = 0; i < 16; i++) o[i] = 8'($urandom);
        return o;
    endfunction

    // Drives one block on the falling edge; tracked valid blocks are queued for the monitor.
    task automatic issue(input st_t ri, input st_t hi, input st_t ti, input st_t ki,
                         input logic [7:0] rc, input logic fin, input logic emp,
                         input bit track, input bit use_exp, input st_t sexp);
        exp_t e;
        @(negedge clock);
        r = ri; h = hi; t = ti; ka = ki;
        rcon_in = rc; final_in = fin; empty_in = emp;
        if (track && !emp) begin
            cnt_model = cnt_model + 8'd1;
            e.s    = use_exp ? sexp : model(ri, hi, ti, ki, fin);
            e.ko   = ki;
            e.rcon = rc;
            e.cnt  = cnt_model;
            e.cyc  = cyc;
            q.push_back(e);
        end
    endtask

    task automatic bubble();
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0 && empty_o === 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_block", {120'h0, cnt_o}, {128{1'b1}});
            end else begin
                e = q.pop_front();
                chk("state", s_o, e.s);
                chk("key", ko_o, e.ko);
                chk("rcon", {120'h0, rcon_o}, {120'h0, e.rcon});
                chk("blk_count", {120'h0, cnt_o}, {120'h0, e.cnt});
                chk("latency", 128'(cyc - e.cyc), 128'd2);
            end
        end
    end

    initial begin
        st_t rr, hh, tt, kk, sx;
        logic fin, emp;
        r = '0; h = '0; t = '0; ka = '0;
        rcon_in = 8'h00; final_in = 1'b0; empty_in = 1'b1;

        #2 reset = 1'b1;
        #2;
        chk("reset_state", s_o, '0);
        chk("reset_key", ko_o, '0);
        chk("reset_empty", {127'h0, empty_o}, 128'd1);
        chk("reset_count", {120'h0, cnt_o}, 128'd0);
        chk("reset_rcon", {120'h0, rcon_o}, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 chk("empty_after_release", {127'h0, empty_o}, 128'd1);

        // FIPS-197 column 0
        rr = '0; hh = '0; tt = '0; kk = '0; sx = '0;
        rr[0] = 8'hd4; rr[1] = 8'hbf; rr[2] = 8'h5d; rr[3] = 8'h30;
        hh[0] = 8'hb3; hh[1] = 8'h65; hh[2] = 8'hba; hh[3] = 8'h60;
        tt[0] = 8'h67; tt[1] = 8'hda; tt[2] = 8'he7; tt[3] = 8'h50;
        sx[0] = 8'h04; sx[1] = 8'h66; sx[2] = 8'h81; sx[3] = 8'he5;
        issue(rr, hh, tt, kk, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, sx);

        // Uniform state with zero and all-ones key
        for (int i = 0; i < 16; i++) begin
            rr[i] = 8'h01; hh[i] = 8'h02; tt[i] = 8'h03; sx[i] = 8'h01;
        end
        issue(rr, hh, tt, '0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, sx);
        for (int i = 0; i < 16; i++) begin
            kk[i] = 8'hff; sx[i] = 8'hfe;
        end
        issue(rr, hh, tt, kk, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, sx);

        // Final round ignores H and T
        for (int i = 0; i < 16; i++) begin
            rr[i] = 8'(i); kk[i] = 8'h0f; sx[i] = 8'(i) ^ 8'h0f;
        end
        issue(rr, rnd_st(), rnd_st(), kk, 8'h08, 1'b1, 1'b0, 1'b1, 1'b1, sx);

        // Block, bubble, block back to back
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Random stream, long enough to wrap blk_count
        for (int n = 0; n < 400; n++) begin
            fin = ($urandom_range(0, 3) == 0);
            emp = ($urandom_range(0, 4) == 0);
            issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'($urandom), fin, emp, 1'b1, 1'b0, '0);
        end
        repeat (4) bubble();
        chk("drained_before_reset", 128'(q.size()), 128'd0);

        // Reset with two untracked blocks in flight
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clock);
        #1 reset = 1'b1;
        empty_in = 1'b1;
        #1;
        chk("midreset_state", s_o, '0);
        chk("midreset_empty", {127'h0, empty_o}, 128'd1);
        chk("midreset_count", {120'h0, cnt_o}, 128'd0);
        cnt_model = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) bubble();
        chk("count_after_reset", {120'h0, cnt_o}, 128'd0);
        issue(rnd_st(), rnd_st(), rnd_st(), rnd_st(), 8'h36, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        repeat (4) bubble();
        chk("drained_at_end", 128'(q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
